// File: rtl/wb_exc_commit.sv
// -----------------------------------------------------------------------------
// wb_exc_commit -- writeback stage with precise exception commit.
//
// Retires the instruction held on the registered MEM_WB bus. Normal
// instructions write the register file combinationally in the cycle they are
// presented. Instructions flagged with an exception take two extra cycles:
// EXC_COMMIT updates CP0 (EPC/Cause/Status.EXL), EXC_REDIR pulses a redirect
// to EXC_VECTOR. ERET redirects to EPC in a single cycle and clears EXL.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   WB_valid            MEM_WB_bus_r holds a live instruction
//   MEM_WB_bus_r[72:0]  {exc_flag, exc_type[1:0], rf_wen, rf_dest[4:0],
//                        wb_data[31:0], pc[31:0]}
//   WB_eret             live instruction is ERET
//   rf_wen/rf_wdest/rf_wdata   register-file write port
//   WB_over             instruction retired this cycle
//   WB_pc               pc of the instruction in WB
//   redirect/redirect_pc       one-cycle fetch redirect and its target
//   cp0_epc/cp0_cause/cp0_status  CP0 registers
//
// Optional feature (macro WB_EXC_CNT_EN): adds exc_cnt, four saturating
// 16-bit per-type exception counters {Ov, Sys, AdES, AdEL}.
// -----------------------------------------------------------------------------
module wb_exc_commit #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_valid,
    input  logic [72:0] MEM_WB_bus_r,
    input  logic        WB_eret,
    output logic        rf_wen,
    output logic [4:0]  rf_wdest,
    output logic [31:0] rf_wdata,
    output logic        WB_over,
    output logic [31:0] WB_pc,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_status
`ifdef WB_EXC_CNT_EN
    ,
    output logic [3:0][15:0] exc_cnt
`endif
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] EXC_COMMIT = 2'd1;
    localparam logic [1:0] EXC_REDIR  = 2'd2;

    // Live bus fields
    logic        bus_exc;
    logic [1:0]  bus_type;
    logic        bus_wen;
    logic [4:0]  bus_dest;
    logic [31:0] bus_data;
    logic [31:0] bus_pc;

    assign {bus_exc, bus_type, bus_wen, bus_dest, bus_data, bus_pc} = MEM_WB_bus_r;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cap_type_q, cap_type_d;
    logic [31:0] cap_pc_q, cap_pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] status_q, status_d;
    logic        exc_entry;

    function automatic logic [4:0] exc_code(input logic [1:0] t);
        case (t)
            2'b00:   exc_code = 5'd4;   // AdEL
            2'b01:   exc_code = 5'd5;   // AdES
            2'b10:   exc_code = 5'd8;   // Sys
            default: exc_code = 5'd12;  // Ov
        endcase
    endfunction

    // Exception wins over ERET when both are presented together.
    assign exc_entry = (state_q == IDLE) && WB_valid && bus_exc;

    always_comb begin
        state_d     = state_q;
        cap_type_d  = cap_type_q;
        cap_pc_d    = cap_pc_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        status_d    = status_q;
        rf_wen      = 1'b0;
        rf_wdest    = 5'd0;
        rf_wdata    = 32'd0;
        WB_over     = 1'b0;
        WB_pc       = WB_valid ? bus_pc : 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        case (state_q)
            IDLE: begin
                if (WB_valid) begin
                    if (bus_exc) begin
                        // Snapshot the faulting instruction; upstream may move on.
                        cap_type_d = bus_type;
                        cap_pc_d   = bus_pc;
                        state_d    = EXC_COMMIT;
                    end else if (WB_eret) begin
                        redirect    = 1'b1;
                        redirect_pc = epc_q;
                        status_d[1] = 1'b0;
                        WB_over     = 1'b1;
                    end else begin
                        // $0 is hard-wired: never write it.
                        rf_wen   = bus_wen && (bus_dest != 5'd0);
                        rf_wdest = rf_wen ? bus_dest : 5'd0;
                        rf_wdata = rf_wen ? bus_data : 32'd0;
                        WB_over  = 1'b1;
                    end
                end
            end
            EXC_COMMIT: begin
                WB_pc = cap_pc_q;
                // A nested exception (EXL already set) keeps the original EPC.
                if (!status_q[1])
                    epc_d = cap_pc_q;
                cause_d     = {25'd0, exc_code(cap_type_q), 2'b00};
                status_d[1] = 1'b1;
                state_d     = EXC_REDIR;
            end
            EXC_REDIR: begin
                WB_pc       = cap_pc_q;
                redirect    = 1'b1;
                redirect_pc = EXC_VECTOR;
                WB_over     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cap_type_q <= 2'd0;
            cap_pc_q   <= 32'd0;
            epc_q      <= 32'd0;
            cause_q    <= 32'd0;
            status_q   <= STATUS_RST;
        end else begin
            state_q    <= state_d;
            cap_type_q <= cap_type_d;
            cap_pc_q   <= cap_pc_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
            status_q   <= status_d;
        end
    end

    assign cp0_epc    = epc_q;
    assign cp0_cause  = cause_q;
    assign cp0_status = status_q;

`ifdef WB_EXC_CNT_EN
    // Index by exc_type directly: 0=AdEL, 1=AdES, 2=Sys, 3=Ov.
    logic [3:0][15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (exc_entry && (cnt_q[bus_type] != 16'hFFFF)) begin
            cnt_q[bus_type] <= cnt_q[bus_type] + 16'd1;
        end
    end

    assign exc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_exc_commit.sv
module tb_wb_exc_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_valid;
    logic [72:0] MEM_WB_bus_r;
    logic        WB_eret;
    logic        rf_wen;
    logic [4:0]  rf_wdest;
    logic [31:0] rf_wdata;
    logic        WB_over;
    logic [31:0] WB_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] cp0_epc, cp0_cause, cp0_status;
`ifdef WB_EXC_CNT_EN
    logic [3:0][15:0] exc_cnt;
`endif

    wb_exc_commit dut (
        .clk(clk), .rst(rst), .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r),
        .WB_eret(WB_eret), .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata),
        .WB_over(WB_over), .WB_pc(WB_pc), .redirect(redirect), .redirect_pc(redirect_pc),
        .cp0_epc(cp0_epc), .cp0_cause(cp0_cause), .cp0_status(cp0_status)
`ifdef WB_EXC_CNT_EN
        , .exc_cnt(exc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wen;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [31:0] status;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [72:0] JUNK = 73'h1_5A5A5A5A_A5A5A5A5_0F;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    function automatic exp_t mk(input logic wen, input logic [4:0] dest, input logic [31:0] data,
                                input logic redir, input logic [31:0] rpc, input logic [31:0] pc,
                                input logic [31:0] epc, input logic [31:0] cause,
                                input logic [31:0] status);
        exp_t e;
        e.wen = wen; e.dest = dest; e.data = data; e.redir = redir; e.rpc = rpc;
        e.pc = pc; e.epc = epc; e.cause = cause; e.status = status; e.cyc = 0;
        return e;
    endfunction

    function automatic logic [72:0] bus(input logic f, input logic [1:0] t, input logic w,
                                        input logic [4:0] d, input logic [31:0] data,
                                        input logic [31:0] pc);
        return {f, t, w, d, data, pc};
    endfunction

    // Present one instruction for one cycle; expect its retirement lat cycles later.
    task automatic issue(input logic [72:0] b, input logic er, input exp_t e, input int lat);
        @(posedge clk); #1;
        e.cyc = cyc + lat;
        q.push_back(e);
        WB_valid = 1'b1; MEM_WB_bus_r = b; WB_eret = er;
        @(posedge clk); #1;
        WB_valid = 1'b0; WB_eret = 1'b0; MEM_WB_bus_r = JUNK;
        repeat (3) @(posedge clk);
    endtask

    // Monitor: every retirement / redirect must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && (WB_over || redirect)) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got WB_over=%0b redirect=%0b at cycle %0d expected none",
                         WB_over, redirect, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("cycle", cyc, e.cyc);
                chk("WB_over", {31'd0, WB_over}, 32'd1);
                chk("rf_wen", {31'd0, rf_wen}, {31'd0, e.wen});
                if (e.wen) begin
                    chk("rf_wdest", {27'd0, rf_wdest}, {27'd0, e.dest});
                    chk("rf_wdata", rf_wdata, e.data);
                end
                chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
                if (e.redir) chk("redirect_pc", redirect_pc, e.rpc);
                chk("WB_pc", WB_pc, e.pc);
                chk("cp0_epc", cp0_epc, e.epc);
                chk("cp0_cause", cp0_cause, e.cause);
                chk("cp0_status", cp0_status, e.status);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; WB_valid = 1'b0; WB_eret = 1'b0; MEM_WB_bus_r = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_WB_over", {31'd0, WB_over}, 32'd0);
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_epc", cp0_epc, 32'd0);
        chk("rst_cause", cp0_cause, 32'd0);
        chk("rst_status", cp0_status, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Normal write
        issue(bus(0, 2'b00, 1, 5'd1, 32'hAAAAAAAA, 32'h00400000), 0,
              mk(1, 5'd1, 32'hAAAAAAAA, 0, 0, 32'h00400000, 0, 0, 0), 0);
        // Write to $0 is suppressed but still retires
        issue(bus(0, 2'b00, 1, 5'd0, 32'h12345678, 32'h00400004), 0,
              mk(0, 5'd0, 0, 0, 0, 32'h00400004, 0, 0, 0), 0);
        // AdES: EPC captured, Cause=5<<2, EXL set, redirect after 2 cycles
        issue(bus(1, 2'b01, 0, 5'd0, 32'd0, 32'h00400008), 0,
              mk(0, 0, 0, 1, 32'h380, 32'h00400008, 32'h00400008, 32'h14, 32'h2), 2);
        // Nested Ov: EPC held, Cause=12<<2
        issue(bus(1, 2'b11, 1, 5'd3, 32'hFFFFFFFF, 32'h0040000C), 0,
              mk(0, 0, 0, 1, 32'h380, 32'h0040000C, 32'h00400008, 32'h30, 32'h2), 2);
        // ERET: same-cycle redirect to EPC; status still shows EXL this cycle
        issue(bus(0, 2'b00, 0, 5'd0, 32'd0, 32'h00400010), 1,
              mk(0, 0, 0, 1, 32'h00400008, 32'h00400010, 32'h00400008, 32'h30, 32'h2), 0);
        // Following write observes EXL cleared
        issue(bus(0, 2'b00, 1, 5'd31, 32'hDEADBEEF, 32'h00400014), 0,
              mk(1, 5'd31, 32'hDEADBEEF, 0, 0, 32'h00400014, 32'h00400008, 32'h30, 32'h0), 0);
        // Exception together with ERET: exception path wins
        issue(bus(1, 2'b00, 0, 5'd0, 32'd0, 32'h00400018), 1,
              mk(0, 0, 0, 1, 32'h380, 32'h00400018, 32'h00400018, 32'h10, 32'h2), 2);

        // Reset during EXC_COMMIT: no redirect, CP0 back to reset values
        @(posedge clk); #1;
        WB_valid = 1'b1; MEM_WB_bus_r = bus(1, 2'b10, 0, 5'd0, 32'd0, 32'h0040001C);
        @(posedge clk); #1;
        WB_valid = 1'b0; MEM_WB_bus_r = JUNK; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstx_redirect", {31'd0, redirect}, 32'd0);
        chk("rstx_WB_over", {31'd0, WB_over}, 32'd0);
        chk("rstx_epc", cp0_epc, 32'd0);
        chk("rstx_cause", cp0_cause, 32'd0);
        chk("rstx_status", cp0_status, 32'd0);
        repeat (3) @(posedge clk);

        // Three AdEL exceptions after reset; the 2nd/3rd are nested
        issue(bus(1, 2'b00, 0, 5'd0, 32'd0, 32'h00400020), 0,
              mk(0, 0, 0, 1, 32'h380, 32'h00400020, 32'h00400020, 32'h10, 32'h2), 2);
        issue(bus(1, 2'b00, 0, 5'd0, 32'd0, 32'h00400024), 0,
              mk(0, 0, 0, 1, 32'h380, 32'h00400024, 32'h00400020, 32'h10, 32'h2), 2);
        issue(bus(1, 2'b00, 0, 5'd0, 32'd0, 32'h00400028), 0,
              mk(0, 0, 0, 1, 32'h380, 32'h00400028, 32'h00400020, 32'h10, 32'h2), 2);
`ifdef WB_EXC_CNT_EN
        @(negedge clk);
        chk("exc_cnt_adel", {16'd0, exc_cnt[0]}, 32'd3);
        chk("exc_cnt_ov", {16'd0, exc_cnt[3]}, 32'd0);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
